// File: rtl/spi_master_regs.sv
// Register-mapped SPI master (mode 0, MSB first) fed by the AXI-Lite IPIF bridge.
// CTRL/STATUS/TXDATA/RXDATA are presented in parallel; the bridge muxes the read word.
module spi_master_regs #(
  parameter int unsigned FRAME_BITS = 8,
  parameter logic [7:0]  DIV_RESET  = 8'd4
) (
  input  logic         ACLK,
  input  logic         ARESETn,
  input  logic [31:0]  bus2ip_data,
  input  logic [3:0]   bus2ip_wrce,
  input  logic [3:0]   bus2ip_rdce,
  output logic [127:0] ip2bus_data,
  output logic         ip2bus_wrack,
  output logic         ip2bus_rdack,
  output logic         spi_sck,
  output logic         spi_mosi,
  input  logic         spi_miso,
  output logic         spi_ss_n
);

  localparam int unsigned HW = $clog2(2 * FRAME_BITS + 1);
  localparam logic [HW-1:0] HALF_LAST = HW'(2 * FRAME_BITS - 1);

  typedef enum logic [1:0] {IDLE, LEAD, XFER, TRAIL} state_t;

  state_t                state, state_next;
  logic                  wr_seen, rd_seen;
  logic                  do_wr, do_rd;
  logic                  wr_ctrl, wr_status, wr_tx, rd_rx;
  logic [7:0]            clkdiv, div_lat, cnt;
  logic                  ss_hold, rx_valid, overrun;
  logic [FRAME_BITS-1:0] txdata, rxdata, shift;
  logic [HW-1:0]         half;
  logic                  cnt_done, busy, frame_done, ss_n_next;
  logic                  unused_bus;

  // One access per assertion of a chip enable: act on its rising edge only.
  assign do_wr     = (|bus2ip_wrce) & ~wr_seen;
  assign do_rd     = (|bus2ip_rdce) & ~rd_seen;
  assign wr_ctrl   = do_wr & bus2ip_wrce[0];
  assign wr_status = do_wr & bus2ip_wrce[1] & ~bus2ip_wrce[0];
  assign wr_tx     = do_wr & bus2ip_wrce[2] & ~(|bus2ip_wrce[1:0]);
  assign rd_rx     = do_rd & bus2ip_rdce[3];

  assign busy       = (state != IDLE);
  assign cnt_done   = (cnt == div_lat);
  assign frame_done = (state == TRAIL) & cnt_done;
  assign unused_bus = &{1'b0, bus2ip_data};

  assign ip2bus_data = {32'(rxdata), 32'(txdata),
                        {29'd0, overrun, rx_valid, busy},
                        {23'd0, ss_hold, clkdiv}};

  // State register.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) state <= IDLE;
    else          state <= state_next;
  end

  // Next state and slave-select target.
  always_comb begin
    state_next = state;
    ss_n_next  = 1'b1;
    case (state)
      IDLE:    if (wr_tx)                           state_next = LEAD;
      LEAD:    if (cnt_done)                        state_next = XFER;
      XFER:    if (cnt_done && (half == HALF_LAST)) state_next = TRAIL;
      TRAIL:   if (cnt_done)                        state_next = IDLE;
      default:                                      state_next = IDLE;
    endcase
    ss_n_next = ~((state_next != IDLE) | (wr_ctrl ? bus2ip_data[8] : ss_hold));
  end

  // Bus acknowledges and register file.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      wr_seen      <= 1'b0;
      rd_seen      <= 1'b0;
      ip2bus_wrack <= 1'b0;
      ip2bus_rdack <= 1'b0;
      clkdiv       <= DIV_RESET;
      ss_hold      <= 1'b0;
      rx_valid     <= 1'b0;
      overrun      <= 1'b0;
      txdata       <= '0;
      rxdata       <= '0;
    end else begin
      wr_seen      <= |bus2ip_wrce;
      rd_seen      <= |bus2ip_rdce;
      ip2bus_wrack <= do_wr;
      ip2bus_rdack <= do_rd;
      if (wr_ctrl) begin
        clkdiv  <= bus2ip_data[7:0];
        ss_hold <= bus2ip_data[8];
      end
      // Frame completion beats a same-cycle clear.
      if (frame_done)                                 rx_valid <= 1'b1;
      else if ((wr_status & bus2ip_data[1]) | rd_rx)  rx_valid <= 1'b0;
      if (wr_tx & busy)                               overrun  <= 1'b1;
      else if (wr_status & bus2ip_data[2])            overrun  <= 1'b0;
      if (wr_tx & ~busy) txdata <= bus2ip_data[FRAME_BITS-1:0];
      if (frame_done)    rxdata <= shift;
    end
  end

  // Half-period timing, shift register and SPI pins.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      cnt      <= 8'd0;
      half     <= '0;
      div_lat  <= 8'd0;
      shift    <= '0;
      spi_sck  <= 1'b0;
      spi_mosi <= 1'b0;
      spi_ss_n <= 1'b1;
    end else begin
      spi_ss_n <= ss_n_next;
      if (state == IDLE) begin
        cnt  <= 8'd0;
        half <= '0;
        if (wr_tx) begin
          div_lat  <= clkdiv;
          shift    <= bus2ip_data[FRAME_BITS-1:0];
          spi_mosi <= bus2ip_data[FRAME_BITS-1];
        end
      end else begin
        cnt <= cnt_done ? 8'd0 : cnt + 8'd1;
        // Even half periods end in a rising edge (sample), odd ones in a falling edge.
        if ((state == XFER) && cnt_done) begin
          half <= half + HW'(1);
          if (!half[0]) begin
            spi_sck <= 1'b1;
            shift   <= (shift << 1) | FRAME_BITS'(spi_miso);
          end else begin
            spi_sck  <= 1'b0;
            spi_mosi <= shift[FRAME_BITS-1];
          end
        end
      end
    end
  end

endmodule
